// File: rtl/risc_spm_pkg.sv
// Shared definitions for the CPU/host memory arbiter: FSM encoding,
// default RAM geometry and requester IDs.
package risc_spm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  localparam int CPU_ID  = 0;
  localparam int HOST_ID = 1;

  localparam int NUM_REQ = 2;

  // Round-robin rule: with both requesting, the one not served last wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    logic pick;
    pick = 1'(CPU_ID);
    case (req)
      2'b01:   pick = 1'(CPU_ID);
      2'b10:   pick = 1'(HOST_ID);
      2'b11:   pick = ~last;
      default: pick = 1'(CPU_ID);
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick between CPU (bit 0) and host (bit 1).
module rr_arb2
  import risc_spm_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       pick
);

  always_comb begin
    valid = |req;
    pick  = rr_pick(req, last);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous single-port RAM between a CPU and a host loader.
// Each access is a fixed four-cycle walk IDLE -> ADDR -> DATA -> DONE.
module mem_arbiter
  import risc_spm_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter bit FIRST_HOST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              gnt_host
);

  state_t            state_reg, state_next;
  logic              winner_reg, winner_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              last_reg, last_next;

  logic [NUM_REQ-1:0] req_vec;
  logic [NUM_REQ-1:0] we_vec;
  logic [NUM_REQ-1:0] ack_vec;
  logic [ADDR_W-1:0]  addr_vec  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_vec [NUM_REQ];

  logic pick_valid;
  logic pick_id;
  logic capture;

  assign req_vec              = {host_req, cpu_req};
  assign we_vec               = {host_we, cpu_we};
  assign addr_vec[CPU_ID]     = cpu_addr;
  assign addr_vec[HOST_ID]    = host_addr;
  assign wdata_vec[CPU_ID]    = cpu_wdata;
  assign wdata_vec[HOST_ID]   = host_wdata;

  rr_arb2 u_arb (
    .req   (req_vec),
    .last  (last_reg),
    .valid (pick_valid),
    .pick  (pick_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      winner_reg <= 1'(CPU_ID);
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      last_reg   <= FIRST_HOST;
    end else begin
      state_reg  <= state_next;
      winner_reg <= winner_next;
      we_reg     <= we_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      last_reg   <= last_next;
    end
  end

  // Outputs decode from the state register so an asynchronous reset
  // removes mem_we before the write edge can occur.
  always_comb begin
    state_next  = state_reg;
    winner_next = winner_reg;
    we_next     = we_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    last_next   = last_reg;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_we      = 1'b0;
    busy        = 1'b1;

    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (pick_valid) begin
          state_next  = ADDR;
          winner_next = pick_id;
          we_next     = we_vec[pick_id];
          addr_next   = addr_vec[pick_id];
          wdata_next  = wdata_vec[pick_id];
          last_next   = pick_id;
        end
      end
      ADDR: begin
        mem_addr   = addr_reg;
        mem_wdata  = wdata_reg;
        mem_we     = we_reg;
        state_next = DATA;
      end
      DATA: begin
        mem_addr   = addr_reg;
        mem_wdata  = wdata_reg;
        state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign capture  = (state_reg == DATA) && !we_reg;
  assign gnt_host = (state_reg != IDLE) && (winner_reg == 1'(HOST_ID));

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_reg <= '0;
      end else if (capture && (winner_reg == 1'(gi))) begin
        rdata_reg <= mem_rdata;
      end
    end

    assign ack_vec[gi] = (state_reg == DONE) && (winner_reg == 1'(gi));
  end

  assign cpu_ack    = ack_vec[CPU_ID];
  assign host_ack   = ack_vec[HOST_ID];
  assign cpu_rdata  = g_port[CPU_ID].rdata_reg;
  assign host_rdata = g_port[HOST_ID].rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a RAM stub, a cycle-count transaction
// model checked every negedge, and hand-computed literal checks.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0] cpu_addr = '0, cpu_wdata = '0;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic       host_req = 1'b0, host_we = 1'b0;
  logic [7:0] host_addr = '0, host_wdata = '0;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we, busy, gnt_host;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIRST_HOST(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .gnt_host   (gnt_host)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM stub: synchronous read, write on mem_we
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Transaction model: cnt = cycles into the current access (0 = idle)
  logic [7:0] shadow [256];
  int         cnt = 0;
  logic       m_id = 1'b0, m_we = 1'b0, m_last = 1'b0;
  logic [7:0] m_addr = '0, m_wdata = '0, m_cpu_rd = '0, m_host_rd = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt = 0; m_last = 1'b0; m_cpu_rd = '0; m_host_rd = '0;
    end else begin
      if (cnt == 0) begin
        if (cpu_req || host_req) begin
          m_id    = (cpu_req && host_req) ? !m_last : host_req;
          m_last  = m_id;
          m_we    = m_id ? host_we : cpu_we;
          m_addr  = m_id ? host_addr : cpu_addr;
          m_wdata = m_id ? host_wdata : cpu_wdata;
          cnt = 1;
        end
      end else if (cnt == 1) begin
        if (m_we) shadow[m_addr] = m_wdata;
        cnt = 2;
      end else if (cnt == 2) begin
        if (!m_we) begin
          if (m_id) m_host_rd = shadow[m_addr];
          else      m_cpu_rd  = shadow[m_addr];
        end
        cnt = 3;
      end else begin
        cnt = 0;
      end
    end
  end

  int we_cycles = 0;
  always @(negedge clk) begin
    if (mem_we) we_cycles++;
    check("busy", 32'(busy), 32'(cnt != 0));
    check("gnt_host", 32'(gnt_host), 32'(cnt != 0 && m_id));
    check("cpu_ack", 32'(cpu_ack), 32'(cnt == 3 && !m_id));
    check("host_ack", 32'(host_ack), 32'(cnt == 3 && m_id));
    check("mem_we", 32'(mem_we), 32'(cnt == 1 && m_we));
    check("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rd));
    check("host_rdata", 32'(host_rdata), 32'(m_host_rd));
    if (cnt == 0) begin
      check("idle_mem_addr", 32'(mem_addr), 32'h0);
      check("idle_mem_wdata", 32'(mem_wdata), 32'h0);
    end
    if (cnt == 1 || cnt == 2) check("mem_addr", 32'(mem_addr), 32'(m_addr));
    if (cnt == 1) check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns edges from request to ack (-1 on timeout)
  task automatic access(input bit host, input bit we, input logic [7:0] addr,
                        input logic [7:0] wdata, output int lat);
    if (host) begin
      host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (host ? host_ack : cpu_ack) begin
        lat = k - 1;
        break;
      end
    end
    if (lat < 0) check("ack_timeout", 32'h0, 32'h1);
    tick(1);
    if (host) host_req = 1'b0; else cpu_req = 1'b0;
  endtask

  initial begin
    int lat;
    int order [4];
    int times [4];
    int n_ack;

    for (int i = 0; i < 256; i++) begin
      ram[i]    = 8'(i * 7 + 3);
      shadow[i] = 8'(i * 7 + 3);
    end
    ram[130] = 8'd2;    shadow[130] = 8'd2;
    ram[5]   = 8'h35;   shadow[5]   = 8'h35;
    ram[9]   = 8'h99;   shadow[9]   = 8'h99;
    ram[128] = 8'h5C;   shadow[128] = 8'h5C;

    tick(3);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
    rst = 1'b0;
    tick(2);

    // Host write 0x86 to 139
    we_cycles = 0;
    access(1'b1, 1'b1, 8'd139, 8'h86, lat);
    $display("host write addr=139 data=0x86 latency=%0d", lat);
    check("t1_latency", 32'(lat), 32'd3);
    check("t1_we_cycles", 32'(we_cycles), 32'd1);
    check("t1_ram139", 32'(ram[139]), 32'h86);
    tick(2);

    // CPU read 130
    access(1'b0, 1'b0, 8'd130, 8'h00, lat);
    $display("cpu read addr=130 data=0x%0h latency=%0d", cpu_rdata, lat);
    check("t2_cpu_rdata", 32'(cpu_rdata), 32'd2);
    tick(3);
    check("t2_rdata_hold", 32'(cpu_rdata), 32'd2);

    // Simultaneous requests after reset, both held for four grants
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'd20; cpu_wdata = 8'h11;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'd139;
    n_ack = 0;
    for (int k = 1; k <= 40 && n_ack < 4; k++) begin
      @(negedge clk);
      if (cpu_ack || host_ack) begin
        order[n_ack] = host_ack ? 1 : 0;
        times[n_ack] = k;
        $display("arb grant %0d to %s at cycle %0d", n_ack, host_ack ? "host" : "cpu", k);
        n_ack++;
      end
    end
    tick(1);
    cpu_req = 1'b0; host_req = 1'b0;
    check("t3_n_ack", 32'(n_ack), 32'd4);
    check("t3_order0", 32'(order[0]), 32'd1);
    check("t3_order1", 32'(order[1]), 32'd0);
    check("t3_order2", 32'(order[2]), 32'd1);
    check("t3_order3", 32'(order[3]), 32'd0);
    check("t3_time0", 32'(times[0]), 32'd4);
    check("t3_time1", 32'(times[1]), 32'd8);
    check("t3_host_rdata", 32'(host_rdata), 32'h86);
    check("t3_ram20", 32'(ram[20]), 32'h11);
    tick(2);

    // Reset during ADDR of a CPU write to 128
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'd128; cpu_wdata = 8'hEE;
    tick(1);
    check("t4_we_in_addr", 32'(mem_we), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("t4_we_dropped", 32'(mem_we), 32'h0);
    check("t4_busy", 32'(busy), 32'h0);
    check("t4_ack", 32'(cpu_ack), 32'h0);
    cpu_req = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(4);
    $display("cpu write addr=128 aborted by reset ram=0x%0h", ram[128]);
    check("t4_ram128", 32'(ram[128]), 32'h5C);

    // CPU read 5; address changes to 9 and req drops during ADDR
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd5;
    tick(1);
    cpu_addr = 8'd9;
    cpu_req  = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (cpu_ack) begin
        lat = k;
        break;
      end
    end
    check("t5_acked", 32'(lat > 0), 32'h1);
    $display("cpu read addr=5 (changed to 9) data=0x%0h", cpu_rdata);
    check("t5_cpu_rdata", 32'(cpu_rdata), 32'h35);
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8: address width of the shared RAM.
REQ-002 Parameter DATA_W, default 8: data width of the shared RAM.
REQ-003 Parameter FIRST_HOST, default 0: requester treated as "last served" after reset (0 = CPU last served, so the host wins the first tie).
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 cpu_req / cpu_we  input  1 each  CPU access request and write enable.
REQ-007 cpu_addr  input  ADDR_W, cpu_wdata  input  DATA_W  CPU address and write data.
REQ-008 cpu_ack  output  1, cpu_rdata  output  DATA_W  CPU completion pulse and read data.
REQ-009 host_req, host_we, host_addr, host_wdata, host_ack, host_rdata: host loader port, same widths and meanings as the CPU set.
REQ-010 mem_addr  output  ADDR_W, mem_wdata  output  DATA_W, mem_we  output  1  drive to the shared single-port RAM.
REQ-011 mem_rdata  input  DATA_W  RAM read data, valid one cycle after the address is driven (synchronous read).
REQ-012 busy  output  1  high in every state except IDLE; gnt_host  output  1  high while the host owns the RAM.

Function
REQ-013 FSM states: IDLE, ADDR, DATA, DONE; one access takes exactly 4 cycles, from IDLE back to IDLE.
REQ-014 IDLE: when any request is sampled high, the FSM latches the winner, the winner's we/addr/wdata, and moves to ADDR; with no request it stays in IDLE.
REQ-015 Arbitration is round-robin between the two requesters: a single request wins; on simultaneous requests the requester not served last wins.
REQ-016 ADDR: mem_addr and mem_wdata carry the latched values; mem_we equals the latched we for this one cycle only.
REQ-017 DATA: mem_addr is held and mem_we = 0; on a read, mem_rdata is captured into the winner's rdata register at the end of the cycle.
REQ-018 DONE: the winner's ack is high for exactly one cycle; the next state is always IDLE.
REQ-019 The loser's ack stays low, and its rdata register holds its last value.
REQ-020 cpu_rdata and host_rdata hold their last captured value until the next completed read on the same port; writes leave them unchanged.
REQ-021 In IDLE, mem_addr, mem_wdata and mem_we are 0.
REQ-022 Requesters hold req, we, addr and wdata stable until ack.
REQ-023 Inputs are latched in IDLE, so a request that drops or changes after latching still completes with the latched values and is acked.
REQ-024 A requester that holds req high through DONE is re-arbitrated in IDLE like any new request.
REQ-025 The last-served pointer updates on the IDLE->ADDR transition.

Reset
REQ-026 rst asynchronously forces state IDLE and clears cpu_ack, host_ack, busy, gnt_host, mem_we, mem_addr, mem_wdata, cpu_rdata and host_rdata to 0.
REQ-027 rst also loads the last-served pointer from FIRST_HOST.
REQ-028 If rst asserts mid-access, the access is aborted with no ack; if it asserts before the ADDR-cycle edge, no RAM write occurs.

Structure
REQ-029 Shared package risc_spm_pkg holds the state encoding, the ADDR_W/DATA_W defaults and the requester-ID constants (CPU = 0, HOST = 1).
REQ-030 A single sub-module rr_arb2 implements the combinational two-way round-robin pick from both requests and the last-served bit.

Verification
REQ-031 Reset, then host write 0x86 to addr 139 -> mem_we high exactly one cycle with mem_addr = 139, mem_wdata = 0x86; host_ack pulses 3 cycles after the req edge; cpu_ack stays 0.
REQ-032 Mem[130] = 2, CPU read addr 130 -> cpu_ack one cycle with cpu_rdata = 2; cpu_rdata stays 2 after ack drops.
REQ-033 cpu_req and host_req rise together after reset (FIRST_HOST = 0) -> host served first, CPU second, 8 cycles total; with both held high, grants alternate CPU/host.
REQ-034 Assert rst during the ADDR cycle of a CPU write to addr 128 -> mem_we drops immediately, mem[128] is unchanged, no ack, busy = 0.
REQ-035 CPU read addr 5 with cpu_addr changed to 9 during ADDR -> RAM is accessed at 5 and returns mem[5]; idle periods show mem_addr = 0 and mem_we = 0.
